// File: rtl/l4_bg_sequencer_pkg.sv
// l4_bg_sequencer_pkg
// Shared definitions for the L4 temporal bitgroup sequencer:
//   PREC_*         precision field encodings (one 2-bit field per operand)
//   get_bg_steps   number of 2-bit slices an operand occupies (4/2/1)
//   state_e        sequencer FSM states
package l4_bg_sequencer_pkg;

  localparam logic [1:0] PREC_8B  = 2'b00;
  localparam logic [1:0] PREC_4B  = 2'b10;
  localparam logic [1:0] PREC_2B  = 2'b11;
  localparam logic [1:0] PREC_ILL = 2'b01;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  // The illegal 01 code falls into the 8b case on purpose.
  function automatic logic [2:0] get_bg_steps(input logic [1:0] prec_field);
    case (prec_field)
      PREC_4B: return 3'd2;
      PREC_2B: return 3'd1;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/l4_bg_sequencer_if.sv
// l4_bg_sequencer_if
// Bundles the job input handshake, the array-side slice bus and the result
// handshake of the L4 bitgroup sequencer.
//   prec/in_valid/in_ready/a/w            job input
//   bg_valid/bg_a/bg_w/bg_a_sgn/bg_w_sgn  slice pair to the array
//   psum                                  partial sum back from the array
//   out_valid/out_ready/out               dot-product result
//   prec_err                              sticky illegal-precision flag
// Modports: slave = sequencer side, master = surrounding datapath.
interface l4_bg_sequencer_if #(
  parameter int N      = 4,
  parameter int PSUM_W = 5 + $clog2(N),
  parameter int OUT_W  = 16 + $clog2(N)
);
  logic [3:0]              prec;
  logic                    in_valid;
  logic                    in_ready;
  logic [8*N-1:0]          a;
  logic [8*N-1:0]          w;
  logic                    bg_valid;
  logic [2*N-1:0]          bg_a;
  logic [2*N-1:0]          bg_w;
  logic                    bg_a_sgn;
  logic                    bg_w_sgn;
  logic signed [PSUM_W-1:0] psum;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out;
  logic                    prec_err;

  modport slave (
    input  prec, in_valid, a, w, psum, out_ready,
    output in_ready, bg_valid, bg_a, bg_w, bg_a_sgn, bg_w_sgn,
           out_valid, out, prec_err
  );

  modport master (
    output prec, in_valid, a, w, psum, out_ready,
    input  in_ready, bg_valid, bg_a, bg_w, bg_a_sgn, bg_w_sgn,
           out_valid, out, prec_err
  );
endinterface

// File: rtl/l4_bg_sequencer_bg_slicer.sv
// l4_bg_sequencer_bg_slicer
// Combinational lane slicer: picks bitgroup idx (bits [2*idx+1:2*idx]) from
// every 8-bit lane of a packed operand and flags it as the signed top
// bitgroup when idx is the last of the operand's steps.
//   ops    in  8*N  packed operands, lane k at [8k+7:8k]
//   idx    in  2    bitgroup index
//   steps  in  3    slices per operand (4/2/1)
//   slice  out 2*N  selected 2-bit slice per lane
//   sgn    out 1    slice is the operand's top (signed) bitgroup
module l4_bg_sequencer_bg_slicer #(
  parameter int N = 4
) (
  input  logic [8*N-1:0] ops,
  input  logic [1:0]     idx,
  input  logic [2:0]     steps,
  output logic [2*N-1:0] slice,
  output logic           sgn
);

  always_comb begin
    slice = '0;
    for (int k = 0; k < N; k++) begin
      slice[2*k +: 2] = ops[8*k + 2*int'(idx) +: 2];
    end
    sgn = ({1'b0, idx} == (steps - 3'd1));
  end

endmodule

// File: rtl/l4_bg_sequencer.sv
// l4_bg_sequencer
// Temporal bitgroup controller for the L4 multiplier array. Latches one job of
// N signed 8b activation/weight lane pairs, issues 2-bit slice pairs to the
// array one per cycle (weight bitgroup outer, activation bitgroup inner),
// shift-accumulates the returned partial sums and hands back one dot product.
//   clk, rst        clock, synchronous active-high reset
//   bus (slave)     job input, slice bus, psum return, result, prec_err
// Parameters: N lanes, ARR_LAT array latency (0..3), PSUM_W, OUT_W.
// Optional build macro BG_SEQ_ZERO_SKIP_EN: slice pairs whose activation or
// weight slices are zero across all lanes are not issued (result unchanged).
//
// state | meaning
// IDLE  | in_ready high, waiting for a job
// RUN   | issuing one slice pair per cycle
// DRAIN | waiting for the last psums to leave the array pipeline
// DONE  | out_valid high, result held until out_ready
module l4_bg_sequencer
  import l4_bg_sequencer_pkg::*;
#(
  parameter int N       = 4,
  parameter int ARR_LAT = 1,
  parameter int PSUM_W  = 5 + $clog2(N),
  parameter int OUT_W   = 16 + $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  l4_bg_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;

  localparam int DL = (ARR_LAT == 0) ? 1 : ARR_LAT;

  logic [1:0]              state, state_nxt;
  logic [8*N-1:0]          a_q, w_q;
  logic [2:0]              sa_q, sw_q, sa_in, sw_in;
  logic [3:0]              a_nz, w_nz;
  logic [15:0]             mask_q, mask_init, mask_left;
  logic [3:0]              cur, shift_now, dly_shift;
  logic                    accept, issue, pending, dly_valid, prec_err_q;
  logic [DL-1:0]           dv;
  logic [3:0]              dsh [DL];
  logic signed [OUT_W-1:0] acc, psum_ext;
  logic [2*N-1:0]          bg_a, bg_w;
  logic                    bg_a_sgn, bg_w_sgn;

  assign accept = (state == S_IDLE) && bus.in_valid;

`ifdef BG_SEQ_ZERO_SKIP_EN
  always_comb begin
    a_nz = '0;
    w_nz = '0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < N; k++) begin
        a_nz[i] = a_nz[i] | (|bus.a[8*k + 2*i +: 2]);
        w_nz[i] = w_nz[i] | (|bus.w[8*k + 2*i +: 2]);
      end
    end
  end
`else
  assign a_nz = 4'hF;
  assign w_nz = 4'hF;
`endif

  // One bit per (i,j) slice pair at index 4*j+i; the lowest set bit is the
  // next pair to issue, which yields j-outer / i-inner order. Skipped pairs
  // simply never get a bit.
  always_comb begin
    sa_in     = get_bg_steps(bus.prec[3:2]);
    sw_in     = get_bg_steps(bus.prec[1:0]);
    mask_init = '0;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        mask_init[4*j+i] = (3'(i) < sa_in) && (3'(j) < sw_in) && a_nz[i] && w_nz[j];
      end
    end
  end

  always_comb begin
    cur = '0;
    for (int k = 15; k >= 0; k--) begin
      if (mask_q[k]) cur = 4'(k);
    end
    mask_left = mask_q & ~(16'd1 << cur);
    issue     = (state == S_RUN) && (mask_q != '0);
    shift_now = {({1'b0, cur[3:2]} + {1'b0, cur[1:0]}), 1'b0};
  end

  l4_bg_sequencer_bg_slicer #(.N(N)) u_slice_a (
    .ops(a_q), .idx(cur[1:0]), .steps(sa_q), .slice(bg_a), .sgn(bg_a_sgn)
  );

  l4_bg_sequencer_bg_slicer #(.N(N)) u_slice_w (
    .ops(w_q), .idx(cur[3:2]), .steps(sw_q), .slice(bg_w), .sgn(bg_w_sgn)
  );

  // Delay line mirrors the array latency so each psum meets its own shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      dv <= '0;
      for (int k = 0; k < DL; k++) dsh[k] <= '0;
    end else begin
      dv[0]  <= issue;
      dsh[0] <= shift_now;
      for (int k = 1; k < DL; k++) begin
        dv[k]  <= dv[k-1];
        dsh[k] <= dsh[k-1];
      end
    end
  end

  generate
    if (ARR_LAT == 0) begin : g_comb_array
      assign dly_valid = issue;
      assign dly_shift = shift_now;
    end else begin : g_piped_array
      assign dly_valid = dv[DL-1];
      assign dly_shift = dsh[DL-1];
    end
  endgenerate

  // Only stages that will still hold a psum next cycle keep DRAIN waiting;
  // the output stage is consumed in the current cycle.
  always_comb begin
    pending = 1'b0;
    for (int k = 0; k < DL - 1; k++) pending = pending | dv[k];
  end

  assign psum_ext = {{(OUT_W-PSUM_W){bus.psum[PSUM_W-1]}}, bus.psum};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.in_valid) state_nxt = S_RUN;
      // An empty mask only happens when every pair was skipped.
      S_RUN:   if (mask_left == '0)
                 state_nxt = ((ARR_LAT == 0) || (mask_q == '0)) ? S_DONE : S_DRAIN;
      S_DRAIN: if (!pending) state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      a_q        <= '0;
      w_q        <= '0;
      sa_q       <= 3'd4;
      sw_q       <= 3'd4;
      mask_q     <= '0;
      acc        <= '0;
      prec_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (dly_valid) acc <= acc + (psum_ext <<< dly_shift);
      if (accept) begin
        a_q    <= bus.a;
        w_q    <= bus.w;
        sa_q   <= sa_in;
        sw_q   <= sw_in;
        mask_q <= mask_init;
        acc    <= '0;
        if ((bus.prec[3:2] == PREC_ILL) || (bus.prec[1:0] == PREC_ILL)) prec_err_q <= 1'b1;
      end else if (state == S_RUN) begin
        mask_q <= mask_left;
      end
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.bg_valid  = issue;
  assign bus.bg_a      = bg_a;
  assign bus.bg_w      = bg_w;
  assign bus.bg_a_sgn  = bg_a_sgn;
  assign bus.bg_w_sgn  = bg_w_sgn;
  assign bus.out_valid = (state == S_DONE);
  assign bus.out       = acc;
  assign bus.prec_err  = prec_err_q;

endmodule

// File: tb/tb_l4_bg_sequencer.sv
module tb_l4_bg_sequencer;
  localparam int N       = 4;
  localparam int ARR_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_chk  = 0;

  always #5 clk = ~clk;

  l4_bg_sequencer_if #(.N(N)) bus ();

  l4_bg_sequencer #(.N(N), .ARR_LAT(ARR_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int nsteps(logic [1:0] f);
    if (f == 2'b10) return 2;
    if (f == 2'b11) return 1;
    return 4;
  endfunction

  function automatic int opval(logic [1:0] f, logic [7:0] b);
    int bits = 2 * nsteps(f);
    int v    = int'(b) & ((1 << bits) - 1);
    if (v >= (1 << (bits - 1))) v = v - (1 << bits);
    return v;
  endfunction

  function automatic int ref_dot(logic [3:0] p, logic [31:0] av, logic [31:0] wv);
    int s = 0;
    for (int k = 0; k < N; k++) s += opval(p[3:2], av[8*k +: 8]) * opval(p[1:0], wv[8*k +: 8]);
    return s;
  endfunction

  function automatic bit slice_nz(logic [31:0] v, int i);
    return (v & (32'h03030303 << (2*i))) != 32'd0;
  endfunction

  function automatic int ref_issued(logic [3:0] p, logic [31:0] av, logic [31:0] wv);
    int sa  = nsteps(p[3:2]);
    int sw  = nsteps(p[1:0]);
    int cnt = sa * sw;
`ifdef BG_SEQ_ZERO_SKIP_EN
    cnt = 0;
    for (int j = 0; j < sw; j++)
      for (int i = 0; i < sa; i++)
        if (slice_nz(av, i) && slice_nz(wv, j)) cnt++;
`endif
    return cnt;
  endfunction

  function automatic int exp_lat(logic [3:0] p, logic [31:0] av, logic [31:0] wv);
    int l = ref_issued(p, av, wv) + ARR_LAT + 1;
    return (l < 2) ? 2 : l;
  endfunction

  // Behavioural array: per-lane 2b x 2b products, signed where flagged.
  function automatic int arr_model(logic [7:0] ba, logic [7:0] bw, logic sa, logic sw);
    int s = 0;
    for (int k = 0; k < N; k++) begin
      int x = int'(ba[2*k +: 2]);
      int y = int'(bw[2*k +: 2]);
      if (sa && x >= 2) x -= 4;
      if (sw && y >= 2) y -= 4;
      s += x * y;
    end
    return s;
  endfunction

  always @(posedge clk) begin
    if (bus.bg_valid) bus.psum <= 7'(arr_model(bus.bg_a, bus.bg_w, bus.bg_a_sgn, bus.bg_w_sgn));
    else              bus.psum <= 7'($urandom);
  end

  // Drives one job from a negedge with the DUT idle; returns bg_valid count,
  // cycle of first out_valid (-1 on timeout) and the result. With hold=1 the
  // result handshake is left pending for the caller.
  task automatic run_job(input logic [3:0] p, input logic [31:0] av, input logic [31:0] wv,
                         input bit hold, output int n_bg, output int lat,
                         output logic signed [17:0] res);
    int guard = 0;
    n_bg = 0;
    lat  = -1;
    res  = '0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.out_ready = !hold;
    bus.prec      = p;
    bus.a         = av;
    bus.w         = wv;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.prec     = 4'($urandom);
    bus.a        = $urandom;
    bus.w        = $urandom;
    for (int c = 1; c <= 100; c++) begin
      if (bus.bg_valid) n_bg++;
      if (bus.out_valid) begin
        lat = c;
        res = bus.out;
        break;
      end
      @(negedge clk);
    end
    if (!hold && lat > 0) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.prec      = 4'b0000;
    bus.a         = '0;
    bus.w         = '0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (bus.in_ready !== 1'b1)  $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);   else n_pass++;
    n_chk++; if (bus.bg_valid !== 1'b0)  $display("FAIL reset_bg_valid: got %b want 0", bus.bg_valid);  else n_pass++;
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_chk++; if (bus.out !== 18'sd0)     $display("FAIL reset_out: got %0d want 0", bus.out);            else n_pass++;
    n_chk++; if (bus.prec_err !== 1'b0)  $display("FAIL reset_prec_err: got %b want 0", bus.prec_err);  else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_fixed(input string nm, input logic [3:0] p, input logic [31:0] av,
                            input logic [31:0] wv, input int want_out);
    int n, lat;
    logic signed [17:0] r;
    run_job(p, av, wv, 1'b0, n, lat, r);
    n_chk++; if (r !== 18'(want_out)) $display("FAIL %s_out: got %0d want %0d", nm, r, want_out); else n_pass++;
    n_chk++; if (r !== 18'(ref_dot(p, av, wv))) $display("FAIL %s_model: got %0d want %0d", nm, r, ref_dot(p, av, wv)); else n_pass++;
    n_chk++; if (n !== ref_issued(p, av, wv)) $display("FAIL %s_bg_count: got %0d want %0d", nm, n, ref_issued(p, av, wv)); else n_pass++;
    n_chk++; if (lat !== exp_lat(p, av, wv)) $display("FAIL %s_latency: got %0d want %0d", nm, lat, exp_lat(p, av, wv)); else n_pass++;
  endtask

  function automatic logic [1:0] pick_field();
    case ($urandom_range(0, 2))
      0:       return 2'b00;
      1:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [31:0] pick_mask();
    case ($urandom_range(0, 4))
      0:       return 32'hFFFFFFFF;
      1:       return 32'h0F0F0F0F;
      2:       return 32'hF0F0F0F0;
      3:       return 32'h03030303;
      default: return 32'hC0C0C0C0;
    endcase
  endfunction

  task automatic test_random();
    int n, lat;
    logic signed [17:0] r;
    logic [3:0]  p;
    logic [31:0] av, wv;
    for (int t = 0; t < 24; t++) begin
      p  = {pick_field(), pick_field()};
      av = $urandom & pick_mask();
      wv = $urandom & pick_mask();
      run_job(p, av, wv, 1'b0, n, lat, r);
      n_chk++; if (r !== 18'(ref_dot(p, av, wv))) $display("FAIL random_out[%0d]: got %0d want %0d", t, r, ref_dot(p, av, wv)); else n_pass++;
      n_chk++; if (n !== ref_issued(p, av, wv)) $display("FAIL random_bg_count[%0d]: got %0d want %0d", t, n, ref_issued(p, av, wv)); else n_pass++;
      n_chk++; if (lat !== exp_lat(p, av, wv)) $display("FAIL random_latency[%0d]: got %0d want %0d", t, lat, exp_lat(p, av, wv)); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int n, lat, want;
    logic signed [17:0] r;
    logic [31:0] av = $urandom;
    logic [31:0] wv = $urandom;
    want = ref_dot(4'b1010, av, wv);
    run_job(4'b1010, av, wv, 1'b1, n, lat, r);
    n_chk++; if (r !== 18'(want)) $display("FAIL bp_out: got %0d want %0d", r, want); else n_pass++;
    n_chk++; if (lat !== exp_lat(4'b1010, av, wv)) $display("FAIL bp_latency: got %0d want %0d", lat, exp_lat(4'b1010, av, wv)); else n_pass++;
    bus.in_valid = 1'b1;
    bus.prec     = 4'b1111;
    bus.a        = $urandom;
    bus.w        = $urandom;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_chk++; if (bus.out_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, bus.out_valid); else n_pass++;
      n_chk++; if (bus.out !== 18'(want)) $display("FAIL bp_hold_out[%0d]: got %0d want %0d", k, bus.out, want); else n_pass++;
      n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", k, bus.in_ready); else n_pass++;
      n_chk++; if (bus.bg_valid !== 1'b0) $display("FAIL bp_no_accept[%0d]: got %b want 0", k, bus.bg_valid); else n_pass++;
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.in_ready !== 1'b1)  $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready);   else n_pass++;
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL bp_release_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_chk++; if (bus.bg_valid !== 1'b0)  $display("FAIL bp_release_bg_valid: got %b want 0", bus.bg_valid);   else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int nb = 0;
    bit seen_ov = 1'b0;
    bus.out_ready = 1'b1;
    bus.prec      = 4'b0000;
    bus.a         = 32'hFFFFFFFF;
    bus.w         = 32'hFFFFFFFF;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.bg_valid) nb++;
      if (nb == 7) break;
      @(negedge clk);
    end
    n_chk++; if (nb !== 7) $display("FAIL midrst_reach_step7: got %0d want 7", nb); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++; if (bus.in_ready !== 1'b1)  $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready);   else n_pass++;
    n_chk++; if (bus.bg_valid !== 1'b0)  $display("FAIL midrst_bg_valid: got %b want 0", bus.bg_valid);  else n_pass++;
    n_chk++; if (bus.out !== 18'sd0)     $display("FAIL midrst_out: got %0d want 0", bus.out);            else n_pass++;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid) seen_ov = 1'b1;
    end
    n_chk++; if (seen_ov !== 1'b0) $display("FAIL midrst_no_out_valid: got %b want 0", seen_ov); else n_pass++;
    test_fixed("midrst_2x2", 4'b1111, 32'h03030303, 32'h01010101, -4);
  endtask

  task automatic test_prec_err();
    int n, lat;
    logic signed [17:0] r;
    logic [31:0] av = $urandom;
    logic [31:0] wv = $urandom;
    run_job(4'b0100, av, wv, 1'b0, n, lat, r);
    n_chk++; if (bus.prec_err !== 1'b1) $display("FAIL perr_set: got %b want 1", bus.prec_err); else n_pass++;
    n_chk++; if (r !== 18'(ref_dot(4'b0000, av, wv))) $display("FAIL perr_as_8x8_out: got %0d want %0d", r, ref_dot(4'b0000, av, wv)); else n_pass++;
    n_chk++; if (n !== ref_issued(4'b0000, av, wv)) $display("FAIL perr_as_8x8_count: got %0d want %0d", n, ref_issued(4'b0000, av, wv)); else n_pass++;
    av = $urandom;
    run_job(4'b1011, av, wv, 1'b0, n, lat, r);
    n_chk++; if (bus.prec_err !== 1'b1) $display("FAIL perr_sticky: got %b want 1", bus.prec_err); else n_pass++;
    n_chk++; if (r !== 18'(ref_dot(4'b1011, av, wv))) $display("FAIL perr_next_out: got %0d want %0d", r, ref_dot(4'b1011, av, wv)); else n_pass++;
    test_fixed("zero_a", 4'b0000, 32'h00000000, wv, 0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_chk++; if (bus.prec_err !== 1'b0) $display("FAIL perr_cleared: got %b want 0", bus.prec_err); else n_pass++;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.prec      = 4'b0000;
    bus.a         = '0;
    bus.w         = '0;
    test_reset();
    test_fixed("job_8x8", 4'b0000, 32'hFFFFFFFF, 32'h02020202, -8);
    test_fixed("job_4x4", 4'b1010, 32'h07070707, 32'h09090909, -196);
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_prec_err();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
